fmap_stream_tx: RTL
===================

Name: fmap_stream_tx

Overview:
- Serializes one parallel feature map into a row-major pixel stream with valid/ready flow control.
- Sits on the output side of the convolution layers and consumes their flattened output bus.
- Provides the egress path to memory, a host link, or the next streaming stage.
- Captures the whole map in one cycle, then emits one pixel-channel element per accepted beat.

Parameters:
- SIZE, 30: map height and width (square); must be ≥1.
- CHANNELS, 3: channels per pixel; must be ≥1.
- PX_SIZE, 8: bits per element.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- fmap_in  input  SIZE*SIZE*CHANNELS*PX_SIZE  map laid out [row][col][ch][bit]; element (r,c,k) at bit offset ((r*SIZE+c)*CHANNELS+k)*PX_SIZE
- fmap_valid  input  1  fmap_in holds a complete map
- fmap_ready  output  1  block can capture a map
- m_data  output  PX_SIZE  current element
- m_valid  output  1  m_data valid
- m_ready  input  1  downstream accepts beat
- m_first  output  1  current beat is element (0,0,0)
- m_last  output  1  current beat is element (SIZE-1,SIZE-1,CHANNELS-1)
- m_eol  output  1  current beat is last element of a row (c=SIZE-1, k=CHANNELS-1)
- done  output  1  one-cycle pulse after final beat accepted

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE, fmap_ready=1, m_valid=0, m_first=0, m_last=0, m_eol=0, done=0, m_data=0, counters r/c/k=0. The capture register is not reset.
- FSM states: IDLE and STREAM.
- IDLE:
  - fmap_ready=1.
  - fmap_valid=1 at edge N → capture fmap_in into the internal register; counters cleared; go to STREAM.
  - m_valid=1 from cycle N+1, so first-beat latency is 1 cycle.
- STREAM:
  - fmap_ready=0. fmap_valid is ignored (no capture); upstream must hold it per valid/ready.
  - m_data = register element (r,c,k), registered or muxed from the registered counters, with no combinational path from m_ready.
  - Beat transfers on an edge where m_valid && m_ready.
  - Counter order: k increments fastest, wraps CHANNELS-1→0 and carries to c; c wraps SIZE-1→0 and carries to r.
- Backpressure: while m_valid && !m_ready, m_data, m_first, m_last and m_eol hold stable; counters hold.
- Final beat: on acceptance of the m_last beat, next cycle m_valid=0, done=1 for one cycle, fmap_ready=1, state=IDLE.
  - A new capture is possible on the edge where done is high, giving a minimum 1 idle cycle between frames.
- Frame length: exactly SIZE*SIZE*CHANNELS beats per frame. m_first only on beat 0; m_last only on the final beat.
- Edge cases for SIZE=1, CHANNELS=1: single beat with m_first=m_last=m_eol=1.
- Reset mid-stream: next cycle m_valid=0 and the frame is discarded; no done pulse.
- Reset together with fmap_valid: reset wins; no capture.
- fmap_in changes after capture: no effect on the stream in progress.
- Counter widths: $clog2 of the bound, minimum 1 bit. No arithmetic on data; elements pass bit-exact.
- Throughput: 1 beat per cycle with m_ready held high.

Test Plan:
- Basic order (SIZE=2, CHANNELS=2, PX_SIZE=8):
  - Stimulus: element (r,c,k) = 8'h10*r + 8'h4*c + k; pulse fmap_valid; m_ready=1.
  - Required: 8 consecutive beats 00,01,04,05,10,11,14,15.
  - m_first on beat 0; m_eol on beats 3 and 7; m_last on beat 7; done on the cycle after; fmap_ready high again that cycle.
- Backpressure: same frame, m_ready toggling 1,0,0,1,... → m_data/flags stable during stalls; same 8-value sequence; no drops or duplicates.
- Busy ignore: assert fmap_valid with a different map during STREAM → no capture; stream still outputs the original values.
  - Keep fmap_valid high through done → second frame captured, first beat appears the cycle after capture.
- Mid-stream reset: assert rst after beat 3 → m_valid=0 next cycle; no done pulse; fmap_ready=1.
  - A new frame then streams from element (0,0,0).
- Degenerate size (SIZE=1, CHANNELS=1, fmap_in=8'hA5) → single beat A5 with m_first=m_eol=m_last=1; done the following cycle.
- Default config (SIZE=30, CHANNELS=3, random map, random m_ready) → exactly 2700 beats, matching a scoreboard in row/col/ch order.

Source files
------------

// File: rtl/fmap_stream_tx.sv
// Feature-map egress: captures a full parallel map in one cycle, then streams it out
// element by element in row/col/channel order over a valid/ready interface.
module fmap_stream_tx #(
    parameter int unsigned SIZE     = 30,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PX_SIZE  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [SIZE*SIZE*CHANNELS*PX_SIZE-1:0]   fmap_in,
    input  logic                                    fmap_valid,
    output logic                                    fmap_ready,
    output logic [PX_SIZE-1:0]                      m_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic                                    m_first,
    output logic                                    m_last,
    output logic                                    m_eol,
    output logic                                    done
);

    localparam int unsigned FMAP_W = SIZE * SIZE * CHANNELS * PX_SIZE;
    localparam int unsigned CW     = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned KW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CW-1:0] POS_MAX = CW'(SIZE - 1);
    localparam logic [KW-1:0] CH_MAX  = KW'(CHANNELS - 1);

    typedef enum logic {
        StIdle,
        StStream
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [FMAP_W-1:0]   r_fmap;
    logic [CW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic [KW-1:0]       r_ch;
    logic                r_done;

    logic w_stream;
    logic w_capture;
    logic w_beat;
    logic w_ch_wrap;
    logic w_col_wrap;
    logic w_row_wrap;
    logic w_last_elem;

    assign w_stream    = (r_state == StStream);
    assign w_capture   = (r_state == StIdle) && fmap_valid;
    assign w_beat      = w_stream && m_ready;
    assign w_ch_wrap   = (r_ch == CH_MAX);
    assign w_col_wrap  = (r_col == POS_MAX);
    assign w_row_wrap  = (r_row == POS_MAX);
    assign w_last_elem = w_row_wrap && w_col_wrap && w_ch_wrap;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (fmap_valid) begin
                    w_state_next = StStream;
                end
            end
            StStream: begin
                if (w_beat && w_last_elem) begin
                    w_state_next = StIdle;
                end
            end
        endcase
    end

    // Position counters and end-of-frame pulse; k is the fastest-moving index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_ch   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_beat && w_last_elem;
            if (w_capture) begin
                r_row <= '0;
                r_col <= '0;
                r_ch  <= '0;
            end else if (w_beat) begin
                if (w_ch_wrap) begin
                    r_ch <= '0;
                    if (w_col_wrap) begin
                        r_col <= '0;
                        if (w_row_wrap) begin
                            r_row <= '0;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end
        end
    end

    // Map is held in a shift register so the current element always sits in the low bits,
    // avoiding a wide read mux over the whole map.
    always_ff @(posedge clk) begin
        if (w_capture && !rst) begin
            r_fmap <= fmap_in;
        end else if (w_beat) begin
            r_fmap <= r_fmap >> PX_SIZE;
        end
    end

    // Outputs depend only on registered state, never on m_ready
    always_comb begin
        fmap_ready = !w_stream;
        m_valid    = w_stream;
        m_data     = w_stream ? r_fmap[PX_SIZE-1:0] : '0;
        m_first    = w_stream && (r_row == '0) && (r_col == '0) && (r_ch == '0);
        m_last     = w_stream && w_last_elem;
        m_eol      = w_stream && w_col_wrap && w_ch_wrap;
        done       = r_done;
    end

`ifndef SYNTHESIS
    a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_first)
                                   && $stable(m_last) && $stable(m_eol)));

    a_done_after_last: assert property (@(posedge clk) disable iff (rst)
        (m_valid && m_ready && m_last) |=> (done && !m_valid && fmap_ready));
`endif

endmodule
